fare_lookup: RTL

//  Parametrised fare-table lookup engine for the ticket machine. Accepts a journey

---
 rtl/fare_pkg.sv | 23 ++
 rtl/fare_lookup_if.sv | 28 ++
 rtl/fare_index_calc.sv | 71 +++++++
 rtl/fare_lookup.sv | 115 +++++++++++
 4 files changed

// File: rtl/fare_pkg.sv
// rtl/fare_pkg.sv - shared types, default fare-table geometry and line helpers
// Line geometry is a packed vector of 8-bit first-station numbers, line 0 in the low byte.
package fare_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, CALC, READ, DONE} state_t;

  localparam int MAX_LINES          = 16;
  localparam int DEF_N_LINES        = 4;
  localparam int DEF_STATIONS_TOTAL = 100;
  localparam logic [DEF_N_LINES*8-1:0] DEF_LINE_BASE = {8'd82, 8'd53, 8'd27, 8'd0};

  function automatic int line_base(input logic [MAX_LINES*8-1:0] base, input int i);
    return int'(base[i*8 +: 8]);
  endfunction

  // The last line runs up to the end of the global station range.
  function automatic int line_len(input logic [MAX_LINES*8-1:0] base, input int n_lines,
                                  input int total, input int i);
    if (i >= n_lines - 1) return total - line_base(base, i);
    return line_base(base, i + 1) - line_base(base, i);
  endfunction

endpackage

// File: rtl/fare_lookup_if.sv
// rtl/fare_lookup_if.sv - journey request / fare response handshake bundle
// The selection FSM is the master; the lookup engine is the slave.
interface fare_lookup_if #(
  parameter int LINE_W    = 2,
  parameter int STATION_W = 7,
  parameter int PRICE_W   = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [LINE_W-1:0]    start_line;
  logic [STATION_W-1:0] start_stn;
  logic [LINE_W-1:0]    end_line;
  logic [STATION_W-1:0] end_stn;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [PRICE_W-1:0]   resp_price;
  logic                 resp_err;

  modport master (
    output req_valid, start_line, start_stn, end_line, end_stn, resp_ready,
    input  req_ready, resp_valid, resp_price, resp_err
  );

  modport slave (
    input  req_valid, start_line, start_stn, end_line, end_stn, resp_ready,
    output req_ready, resp_valid, resp_price, resp_err
  );
endinterface

// File: rtl/fare_index_calc.sv
// rtl/fare_index_calc.sv - range check, global station numbers and flat table index
// check_en_i registers err/same/from/to; load_i then registers from*STATIONS_TOTAL+to.
module fare_index_calc
  import fare_pkg::*;
#(
  parameter int                     N_LINES        = DEF_N_LINES,
  parameter int                     STATIONS_TOTAL = DEF_STATIONS_TOTAL,
  parameter logic [N_LINES*8-1:0]   LINE_BASE      = DEF_LINE_BASE,
  parameter int                     LINE_W         = 2,
  parameter int                     STATION_W      = 7,
  parameter int                     ADDR_W         = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 check_en_i,
  input  logic                 load_i,
  input  logic [LINE_W-1:0]    sl_i,
  input  logic [STATION_W-1:0] ss_i,
  input  logic [LINE_W-1:0]    el_i,
  input  logic [STATION_W-1:0] es_i,
  output logic                 err_o,
  output logic                 same_o,
  output logic [ADDR_W-1:0]    addr_o
);

  localparam logic [MAX_LINES*8-1:0] BASE_EXT = (MAX_LINES*8)'(LINE_BASE);

  logic              s_line_ok, e_line_ok, err_d, same_d;
  logic [ADDR_W-1:0] from_d, to_d;
  logic              err_q, same_q;
  logic [ADDR_W-1:0] from_q, to_q, addr_q;

  // Line lengths and bases are only looked up once the line number is known valid.
  always_comb begin
    s_line_ok = 32'(sl_i) < 32'(N_LINES);
    e_line_ok = 32'(el_i) < 32'(N_LINES);
    err_d     = 1'b1;
    from_d    = '0;
    to_d      = '0;
    if (s_line_ok && e_line_ok) begin
      err_d  = (32'(ss_i) >= line_len(BASE_EXT, N_LINES, STATIONS_TOTAL, 32'(sl_i)))
            || (32'(es_i) >= line_len(BASE_EXT, N_LINES, STATIONS_TOTAL, 32'(el_i)));
      from_d = ADDR_W'(line_base(BASE_EXT, 32'(sl_i)) + 32'(ss_i));
      to_d   = ADDR_W'(line_base(BASE_EXT, 32'(el_i)) + 32'(es_i));
    end
    same_d = !err_d && (from_d == to_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      same_q <= 1'b0;
      from_q <= '0;
      to_q   <= '0;
      addr_q <= '0;
    end else begin
      if (check_en_i) begin
        err_q  <= err_d;
        same_q <= same_d;
        from_q <= from_d;
        to_q   <= to_d;
      end
      if (load_i) addr_q <= from_q * ADDR_W'(STATIONS_TOTAL) + to_q;
    end
  end

  assign err_o  = err_q;
  assign same_o = same_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/fare_lookup.sv
// rtl/fare_lookup.sv - fare-table lookup engine between selection FSM and price BRAM
// One request in flight; BRAM port A lives outside and is read once per valid journey.
module fare_lookup
  import fare_pkg::*;
#(
  parameter int                   N_LINES        = DEF_N_LINES,
  parameter int                   STATIONS_TOTAL = DEF_STATIONS_TOTAL,
  parameter logic [N_LINES*8-1:0] LINE_BASE      = DEF_LINE_BASE,
  parameter int                   STATION_W      = 7,
  parameter int                   ADDR_W         = 19,
  parameter int                   PRICE_W        = 4,
  parameter int                   RAM_LAT        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  fare_lookup_if.slave        bus,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [PRICE_W-1:0]  ram_dout
);

  localparam int LINE_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;

  state_t               state_q, state_d;
  logic [1:0]           lat_cnt_q, lat_cnt_d;
  logic [PRICE_W-1:0]   price_q, price_d;
  logic                 rerr_q, rerr_d;
  logic                 ram_en_q, ram_en_d;
  logic [LINE_W-1:0]    sl_q, el_q;
  logic [STATION_W-1:0] ss_q, es_q;
  logic                 check_en, load_addr, idx_err, idx_same;

  fare_index_calc #(
    .N_LINES(N_LINES), .STATIONS_TOTAL(STATIONS_TOTAL), .LINE_BASE(LINE_BASE),
    .LINE_W(LINE_W), .STATION_W(STATION_W), .ADDR_W(ADDR_W)
  ) u_index (
    .clk(clk), .rst_n(rst_n), .check_en_i(check_en), .load_i(load_addr),
    .sl_i(sl_q), .ss_i(ss_q), .el_i(el_q), .es_i(es_q),
    .err_o(idx_err), .same_o(idx_same), .addr_o(ram_addr)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    price_d   = price_q;
    rerr_d    = rerr_q;
    ram_en_d  = 1'b0;
    check_en  = 1'b0;
    load_addr = 1'b0;
    case (state_q)
      IDLE:  if (bus.req_valid) state_d = CHECK;
      CHECK: begin
        check_en = 1'b1;
        state_d  = CALC;
      end
      // Error and same-station results leave here without touching the RAM.
      CALC: begin
        if (idx_err || idx_same) begin
          price_d = '0;
          rerr_d  = idx_err;
          state_d = DONE;
        end else begin
          load_addr = 1'b1;
          ram_en_d  = 1'b1;
          lat_cnt_d = '0;
          state_d   = READ;
        end
      end
      READ: begin
        if (lat_cnt_q == 2'(RAM_LAT)) begin
          price_d = ram_dout;
          rerr_d  = 1'b0;
          state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      DONE:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      price_q   <= '0;
      rerr_q    <= 1'b0;
      ram_en_q  <= 1'b0;
      sl_q      <= '0;
      ss_q      <= '0;
      el_q      <= '0;
      es_q      <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      price_q   <= price_d;
      rerr_q    <= rerr_d;
      ram_en_q  <= ram_en_d;
      if (state_q == IDLE && bus.req_valid) begin
        sl_q <= bus.start_line;
        ss_q <= bus.start_stn;
        el_q <= bus.end_line;
        es_q <= bus.end_stn;
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_price = price_q;
  assign bus.resp_err   = rerr_q;
  assign ram_en         = ram_en_q;

endmodule
